// File: rtl/dc_ipu_tc_gen.sv
// Horizontal texture-coordinate generator: DDA accumulator producing one
// fixed-point source x coordinate per output pixel, split into int/fract.
module dc_ipu_tc_gen #(
    parameter int TEX_SIZE_WIDTH   = 12,
    parameter int TEX_FRACT_WIDTH  = 8,
    parameter int OUT_SIZE_WIDTH   = 12,
    parameter int STEP_FRACT_WIDTH = 16
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       ctl_start,
    input  logic                                       ctl_abort,
    input  logic [OUT_SIZE_WIDTH-1:0]                  ctl_out_width,
    input  logic [TEX_SIZE_WIDTH+STEP_FRACT_WIDTH-1:0] ctl_step,
    input  logic [TEX_SIZE_WIDTH+STEP_FRACT_WIDTH-1:0] ctl_offset,
    output logic                                       ctl_busy,
    output logic                                       ctl_done,
    output logic                                       tc_valid,
    input  logic                                       tc_ready,
    output logic [TEX_SIZE_WIDTH-1:0]                  tc_int,
    output logic [TEX_FRACT_WIDTH-1:0]                 tc_fract
);

    localparam int ACC_W = TEX_SIZE_WIDTH + STEP_FRACT_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic [ACC_W-1:0]          step_q, step_d;
    logic [OUT_SIZE_WIDTH-1:0] cnt_q, cnt_d;
    logic                      xfer;

    assign xfer = (state_q == RUN) && tc_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        // Start overrides everything, including a simultaneous abort or a line in flight.
        if (ctl_start) begin
            acc_d   = ctl_offset;
            step_d  = ctl_step;
            cnt_d   = ctl_out_width;
            state_d = (ctl_out_width == '0) ? DONE : RUN;
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                RUN: begin
                    if (ctl_abort) begin
                        state_d = IDLE;
                    end else if (xfer) begin
                        acc_d = acc_q + step_q;
                        cnt_d = cnt_q - OUT_SIZE_WIDTH'(1);
                        if (cnt_q == OUT_SIZE_WIDTH'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
        end
    end

    // All outputs are pure register decodes; no path from tc_ready.
    assign tc_valid = (state_q == RUN);
    assign ctl_busy = (state_q == RUN);
    assign ctl_done = (state_q == DONE);
    assign tc_int   = acc_q[ACC_W-1:STEP_FRACT_WIDTH];
    assign tc_fract = acc_q[STEP_FRACT_WIDTH-1:STEP_FRACT_WIDTH-TEX_FRACT_WIDTH];

endmodule

// File: tb/tb_dc_ipu_tc_gen.sv
// Directed self-checking bench for dc_ipu_tc_gen.
module tb_dc_ipu_tc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctl_start;
    logic        ctl_abort;
    logic [11:0] ctl_out_width;
    logic [27:0] ctl_step;
    logic [27:0] ctl_offset;
    logic        ctl_busy;
    logic        ctl_done;
    logic        tc_valid;
    logic        tc_ready;
    logic [11:0] tc_int;
    logic [7:0]  tc_fract;

    int tests = 0;
    int fails = 0;
    int xfers = 0;

    dc_ipu_tc_gen #(
        .TEX_SIZE_WIDTH  (12),
        .TEX_FRACT_WIDTH (8),
        .OUT_SIZE_WIDTH  (12),
        .STEP_FRACT_WIDTH(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ctl_start    (ctl_start),
        .ctl_abort    (ctl_abort),
        .ctl_out_width(ctl_out_width),
        .ctl_step     (ctl_step),
        .ctl_offset   (ctl_offset),
        .ctl_busy     (ctl_busy),
        .ctl_done     (ctl_done),
        .tc_valid     (tc_valid),
        .tc_ready     (tc_ready),
        .tc_int       (tc_int),
        .tc_fract     (tc_fract)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tc_valid && tc_ready) xfers <= xfers + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_tc(input string tag, input logic [11:0] ei, input logic [7:0] ef);
        chk({tag, ".valid"}, 32'(tc_valid), 32'h1);
        chk({tag, ".int"},   32'(tc_int),   32'(ei));
        chk({tag, ".fract"}, 32'(tc_fract), 32'(ef));
    endtask

    task automatic start_line(input logic [27:0] off, input logic [27:0] stp, input logic [11:0] w);
        ctl_start     = 1'b1;
        ctl_offset    = off;
        ctl_step      = stp;
        ctl_out_width = w;
        tick();
        ctl_start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ctl_start = 1'b0; ctl_abort = 1'b0; tc_ready = 1'b1;
        ctl_out_width = '0; ctl_step = '0; ctl_offset = '0;
        tick(); tick();
        chk("rst.valid", 32'(tc_valid), 32'h0);
        chk("rst.busy",  32'(ctl_busy), 32'h0);
        chk("rst.done",  32'(ctl_done), 32'h0);
        chk("rst.int",   32'(tc_int),   32'h0);
        chk("rst.fract", 32'(tc_fract), 32'h0);
        reset = 1'b0;
        tick();

        // Upscale by 2
        chk("up.pre_valid", 32'(tc_valid), 32'h0);
        start_line(28'h0000000, 28'h0008000, 12'd4);
        chk("up.busy", 32'(ctl_busy), 32'h1);
        chk_tc("up0", 12'h000, 8'h00); tick();
        chk_tc("up1", 12'h000, 8'h80); tick();
        chk_tc("up2", 12'h001, 8'h00); tick();
        chk_tc("up3", 12'h001, 8'h80);
        chk("up3.done", 32'(ctl_done), 32'h0);
        tick();
        chk("up.done",  32'(ctl_done), 32'h1);
        chk("up.valid_off", 32'(tc_valid), 32'h0);
        tick();
        chk("up.done_low", 32'(ctl_done), 32'h0);
        chk("up.busy_low", 32'(ctl_busy), 32'h0);

        // Negative start offset (-0.25)
        start_line(28'hFFFC000, 28'h0010000, 12'd3);
        chk_tc("neg0", 12'hFFF, 8'hC0); tick();
        chk_tc("neg1", 12'h000, 8'hC0); tick();
        chk_tc("neg2", 12'h001, 8'hC0); tick();
        chk("neg.done", 32'(ctl_done), 32'h1);
        tick();

        // Backpressure on the second coordinate
        xfers = 0;
        start_line(28'h0000000, 28'h0018000, 12'd3);
        chk_tc("bp0", 12'h000, 8'h00); tick();
        chk_tc("bp1", 12'h001, 8'h80);
        tc_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_tc("bp.stall", 12'h001, 8'h80);
        end
        tc_ready = 1'b1;
        tick();
        chk_tc("bp2", 12'h003, 8'h00); tick();
        chk("bp.done", 32'(ctl_done), 32'h1);
        chk("bp.xfers", 32'(xfers), 32'd3);
        tick();

        // Zero width
        start_line(28'h0000000, 28'h0010000, 12'd0);
        chk("zw.valid", 32'(tc_valid), 32'h0);
        chk("zw.busy",  32'(ctl_busy), 32'h0);
        chk("zw.done",  32'(ctl_done), 32'h1);
        tick();
        chk("zw.done_low", 32'(ctl_done), 32'h0);
        chk("zw.valid2",   32'(tc_valid), 32'h0);

        // Abort after two transfers, then restart
        start_line(28'h0000000, 28'h0010000, 12'd8);
        chk_tc("ab0", 12'h000, 8'h00); tick();
        chk_tc("ab1", 12'h001, 8'h00); tick();
        chk_tc("ab2", 12'h002, 8'h00);
        ctl_abort = 1'b1;
        tick();
        ctl_abort = 1'b0;
        chk("ab.valid", 32'(tc_valid), 32'h0);
        chk("ab.busy",  32'(ctl_busy), 32'h0);
        chk("ab.done",  32'(ctl_done), 32'h0);
        tick();
        chk("ab.done2", 32'(ctl_done), 32'h0);
        start_line(28'h0020000, 28'h0010000, 12'd2);
        chk_tc("rs0", 12'h002, 8'h00); tick();
        chk_tc("rs1", 12'h003, 8'h00); tick();
        chk("rs.done", 32'(ctl_done), 32'h1);
        tick();

        // Start and abort together mid-line: start wins
        start_line(28'h0000000, 28'h0010000, 12'd4);
        tick();
        chk_tc("sa.pre", 12'h001, 8'h00);
        ctl_abort = 1'b1;
        start_line(28'h0050000, 28'h0010000, 12'd2);
        ctl_abort = 1'b0;
        chk("sa.busy", 32'(ctl_busy), 32'h1);
        chk("sa.done", 32'(ctl_done), 32'h0);
        chk_tc("sa0", 12'h005, 8'h00); tick();
        chk_tc("sa1", 12'h006, 8'h00);

        // Reset during RUN
        reset = 1'b1;
        tick();
        chk("mr.valid", 32'(tc_valid), 32'h0);
        chk("mr.busy",  32'(ctl_busy), 32'h0);
        chk("mr.done",  32'(ctl_done), 32'h0);
        chk("mr.int",   32'(tc_int),   32'h0);
        chk("mr.fract", 32'(tc_fract), 32'h0);
        reset = 1'b0;
        tick();
        chk("mr.done2",  32'(ctl_done), 32'h0);
        chk("mr.valid2", 32'(tc_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dc_ipu_tc_gen.md
Name: dc_ipu_tc_gen

Overview:
Horizontal texture-coordinate generator for the image processing unit scaler. For each output line it produces ctl_out_width fixed-point source x coordinates using a DDA accumulator (start offset plus constant step). Each coordinate is split into a signed integer texel index and an unsigned fraction. It sits directly upstream of the gather stage and drives that stage's tc_valid/tc_ready/tc_int/tc_fract interface with non-decreasing coordinates.

Parameters:
TEX_SIZE_WIDTH, 12, width of the signed integer texel coordinate (tc_int).
TEX_FRACT_WIDTH, 8, width of the output fraction (tc_fract).
OUT_SIZE_WIDTH, 12, width of the output pixel count.
STEP_FRACT_WIDTH, 16, fractional bits of step, offset and accumulator; must be >= TEX_FRACT_WIDTH.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
ctl_start  in  1  single-cycle pulse; latches the ctl_* values and starts a line.
ctl_abort  in  1  single-cycle pulse; terminates the current line.
ctl_out_width  in  OUT_SIZE_WIDTH  number of coordinates for the line (unsigned).
ctl_step  in  TEX_SIZE_WIDTH+STEP_FRACT_WIDTH  unsigned source increment per output pixel.
ctl_offset  in  TEX_SIZE_WIDTH+STEP_FRACT_WIDTH  signed two's-complement first coordinate.
ctl_busy  out  1  high while a line is being generated.
ctl_done  out  1  one-cycle pulse after the last coordinate transfer.
tc_valid  out  1  coordinate valid.
tc_ready  in  1  downstream accepts.
tc_int  out  TEX_SIZE_WIDTH  signed integer part of the coordinate.
tc_fract  out  TEX_FRACT_WIDTH  top TEX_FRACT_WIDTH fraction bits (truncated).

Behaviour:
- Accumulator acc_r: signed, ACC_W = TEX_SIZE_WIDTH+STEP_FRACT_WIDTH bits.
  - tc_int = acc_r[ACC_W-1:STEP_FRACT_WIDTH].
  - tc_fract = acc_r[STEP_FRACT_WIDTH-1:STEP_FRACT_WIDTH-TEX_FRACT_WIDTH].
  - Addition wraps modulo 2^ACC_W with no saturation. Software guarantees no overflow. Horizontal edge clamping is the gather stage's job.
- Registers: step_r, width_r, remaining counter cnt_r (OUT_SIZE_WIDTH), FSM state.
- FSM states:
  - IDLE: ctl_start -> RUN; otherwise stay.
  - RUN: on each transfer (tc_valid && tc_ready), acc_r += step_r and cnt_r -= 1. On the transfer with cnt_r==1 -> DONE.
  - DONE: ctl_done=1 for exactly this cycle, then -> IDLE.
- ctl_start, in any state: on the next edge acc_r=ctl_offset, step_r=ctl_step, cnt_r=ctl_out_width, state=RUN. tc_valid rises the cycle after ctl_start (latency 1), carrying ctl_offset.
- ctl_start with ctl_out_width==0: state goes to DONE, not RUN. tc_valid never asserts; ctl_done pulses one cycle after start.
- ctl_start while RUN/DONE: restarts the line immediately. Any pending coordinate is dropped and no ctl_done is produced for the aborted line.
- ctl_abort in RUN or DONE: next state IDLE, tc_valid=0 next cycle, no ctl_done. ctl_abort in IDLE is ignored.
- ctl_start and ctl_abort in the same cycle: start wins.
- Output signals:
  - tc_valid = (state==RUN); it is a registered state decode, with no combinational path from tc_ready.
  - While tc_valid && !tc_ready, tc_int and tc_fract hold stable.
  - ctl_busy = (state==RUN).
- Throughput: one coordinate per cycle while tc_ready=1.
- Coordinates are non-decreasing (step is unsigned), which the gather stage requires.
- Reset: state=IDLE; acc_r, step_r, width_r, cnt_r = 0.
  - Outputs: tc_valid=0, ctl_busy=0, ctl_done=0, tc_int=0, tc_fract=0.
  - Reset asserted mid-line wins over every other input; there is no output activity the following cycle.

Test Plan:
- Upscale: offset 0, step 0x8000 (0.5), width 4, tc_ready=1 -> (tc_int,tc_fract) = (0,0x00),(0,0x80),(1,0x00),(1,0x80) on 4 consecutive cycles. tc_valid first asserts 1 cycle after start; ctl_done pulses the cycle after the 4th transfer.
- Negative offset: offset -0x4000 (-0.25), step 0x10000, width 3 -> (-1,0xC0),(0,0xC0),(1,0xC0); tc_int bit pattern for -1 is all ones.
- Backpressure: step 0x18000 (1.5), width 3, tc_ready low for 5 cycles at the second coordinate -> (1,0x80) held stable for the whole stall. Sequence completes as (0,0),(1,0x80),(3,0x00) with exactly 3 transfers.
- Zero width: ctl_out_width=0 -> tc_valid never asserts; ctl_done is high exactly 1 cycle after start; ctl_busy stays 0.
- Abort and restart: ctl_abort after 2 of 8 transfers -> tc_valid=0 next cycle, no ctl_done. A new start with offset 0x20000 then yields tc_int=2 first.
- Start+abort in the same cycle, and reset asserted during RUN -> start wins in the first case. After reset, all outputs are 0 the next cycle and ctl_done is never asserted.
